glb_core_strm_router_mc: RTL
============================

GLB_CORE_STRM_ROUTER_MC -- requirements
Module: glb_core_strm_router_mc

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent stream channels.
REQ-002 Parameter DATA_W, default 64: payload width per channel, excluding the valid bit.
REQ-003 Parameter PIPE_DEPTH, default 1, legal range 1..4: register stages on each inbound west and east path.
REQ-004 Parameter CNT_W, default 16: width of the per-channel packet counter.
REQ-005 clk  in  1  single clock; all flops use the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 clk_en  in  1  global advance enable; when 0, every flop holds its value.
REQ-008 glb_tile_id  in  TILE_SEL_ADDR_WIDTH  tile index; bit 0 gives the base parity.
REQ-009 w2e_wsti_vld / w2e_wsti_data  in  NUM_CH / NUM_CH x DATA_W  eastbound input from the west neighbour.
REQ-010 e2w_esti_vld / e2w_esti_data  in  NUM_CH / NUM_CH x DATA_W  westbound input from the east neighbour.
REQ-011 sw2sr_vld / sw2sr_data  in  NUM_CH / NUM_CH x DATA_W  local core injection.
REQ-012 w2e_esto_vld / w2e_esto_data  out  NUM_CH / NUM_CH x DATA_W  eastbound output.
REQ-013 e2w_wsto_vld / e2w_wsto_data  out  NUM_CH / NUM_CH x DATA_W  westbound output.
REQ-014 sr2sw_vld / sr2sw_data  out  NUM_CH / NUM_CH x DATA_W  delivery to the local core.
REQ-015 cfg_tile_connected_prev / cfg_tile_connected_next  in  NUM_CH each  per-channel chain links.
REQ-016 cfg_ch_en  in  NUM_CH  per-channel enable.
REQ-017 cfg_parity_inv  in  NUM_CH  inverts the per-channel even/odd role.
REQ-018 cnt_clr  in  1  synchronous clear of all packet counters.
REQ-019 stat_pkt_cnt  out  NUM_CH x CNT_W  packets delivered on sr2sw.

Function
REQ-020 Per channel c: even(c) = ~(glb_tile_id[0] ^ cfg_parity_inv[c]).
REQ-021 Inbound paths: w2e_wsti and e2w_esti each pass through a PIPE_DEPTH-stage pipe (w_p, e_p); sw2sr passes through one stage (s_d1).
REQ-022 Turnaround, west side: w_turn = cfg_tile_connected_prev ? w_p : e2w_wsto_int.
REQ-023 Turnaround, east side: e_turn = cfg_tile_connected_next ? e_p : w2e_esto_int.
REQ-024 w_turn and e_turn are each registered one stage (w_turn_d1, e_turn_d1).
REQ-025 Switch outputs: sr2sw = even ? w_turn : e_turn.
REQ-026 Switch outputs: w2e_esto_int = even ? s_d1 : w_turn_d1.
REQ-027 Switch outputs: e2w_wsto_int = even ? e_turn_d1 : s_d1.
REQ-028 Every stage carries valid and data together; any output whose valid is 0 drives data 0.
REQ-029 Latency with clk_en held 1, even, connected prev: w2e_wsti -> sr2sw = PIPE_DEPTH cycles.
REQ-030 Latency, even: sw2sr -> w2e_esto = 1 cycle.
REQ-031 Latency, odd, both links connected: w2e_wsti -> w2e_esto = PIPE_DEPTH+1 cycles.
REQ-032 Latency, even, next unconnected: sw2sr -> e2w_wsto = 2 cycles via the turnaround.
REQ-033 Configuration where both links are unconnected: the combinational loop through the turnarounds is broken by the w_turn_d1/e_turn_d1 stages, so no combinational loop exists.
REQ-034 When cfg_ch_en[c]=0: all channel-c stages synchronously load 0 on each clk_en cycle, and all channel-c outputs read 0 combinationally.
REQ-035 stat_pkt_cnt[c] increments by 1 on each clk_en cycle in which sr2sw_vld[c]=1.
REQ-036 stat_pkt_cnt[c] saturates at 2^CNT_W-1.
REQ-037 cnt_clr, sampled on a clk_en cycle, zeroes all counters and takes precedence over a same-cycle increment.
REQ-038 Configuration inputs are quasi-static; changing them mid-stream is allowed, packets in flight may be lost or misrouted, and no X is produced.

Reset
REQ-039 Reset asynchronously zeroes all pipe stages, turn stages, s_d1 and counters; all outputs therefore read 0 during reset.
REQ-040 Reset asserted mid-stream discards all in-flight packets; the first valid output after release comes only from post-release inputs.

Structure
REQ-041 The shared package (global_buffer_pkg) holds GLB_STRM_NUM_CH, GLB_STRM_PIPE_DEPTH and TILE_SEL_ADDR_WIDTH.
REQ-042 One sub-module glb_strm_pipe (parameters DEPTH and WIDTH; ports clk, reset, clk_en, clr) is used for each inbound pipe.

Verification
REQ-043 PIPE_DEPTH=2, even tile, prev connected: w2e_wsti vld=1, data=0xA5 at cycle 0 -> sr2sw vld=1, data=0xA5 at cycle 2; stat_pkt_cnt=1.
REQ-044 Odd tile, both links connected, PIPE_DEPTH=1: w2e_wsti 0x11 at cycle 0 -> w2e_esto 0x11 at cycle 2; sw2sr 0x22 at cycle 0 -> e2w_wsto 0x22 at cycle 1.
REQ-045 Even tile, next unconnected: sw2sr 0x33 at cycle 0 -> w2e_esto at cycle 1 and e2w_wsto at cycle 2, both 0x33.
REQ-046 NUM_CH=2, cfg_parity_inv=2'b10, both channels fed the same inputs: the two channels route to opposite outputs; cfg_ch_en[1]=0 -> channel-1 outputs stay 0.
REQ-047 CNT_W=4 with 20 consecutive valid deliveries -> counter reads 15; cnt_clr asserted together with a valid delivery -> counter reads 0.
REQ-048 Reset pulsed while 3 packets are in flight -> all outputs 0 immediately; no stale packet emerges after release; clk_en=0 for 5 cycles -> all outputs frozen.

Source files
------------

// File: rtl/global_buffer_pkg.sv
// Shared global-buffer constants and small helpers used by the stream router.
package global_buffer_pkg;

  localparam int GLB_STRM_NUM_CH     = 2;
  localparam int GLB_STRM_PIPE_DEPTH = 1;
  localparam int TILE_SEL_ADDR_WIDTH = 5;

  // Even tiles feed the local core from the west and inject eastward.
  function automatic logic ch_is_even(input logic tile_lsb, input logic parity_inv);
    return ~(tile_lsb ^ parity_inv);
  endfunction

endpackage

// File: rtl/glb_strm_pipe.sv
// Shift-register pipe of DEPTH stages; clr loads zero into every stage on an enabled cycle.
module glb_strm_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage <= '0;
    end else if (clk_en) begin
      if (clr) begin
        stage <= '0;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/glb_core_strm_router_mc.sv
// Multi-channel stream router: west/east pass-through with turnaround at chain ends,
// local inject/deliver by tile parity, and a saturating per-channel delivery counter.
module glb_core_strm_router_mc
  import global_buffer_pkg::*;
#(
  parameter int NUM_CH     = GLB_STRM_NUM_CH,
  parameter int DATA_W     = 64,
  parameter int PIPE_DEPTH = GLB_STRM_PIPE_DEPTH,
  parameter int CNT_W      = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clk_en,
  input  logic [TILE_SEL_ADDR_WIDTH-1:0]    glb_tile_id,
  input  logic [NUM_CH-1:0]                 w2e_wsti_vld,
  input  logic [NUM_CH-1:0][DATA_W-1:0]     w2e_wsti_data,
  input  logic [NUM_CH-1:0]                 e2w_esti_vld,
  input  logic [NUM_CH-1:0][DATA_W-1:0]     e2w_esti_data,
  input  logic [NUM_CH-1:0]                 sw2sr_vld,
  input  logic [NUM_CH-1:0][DATA_W-1:0]     sw2sr_data,
  output logic [NUM_CH-1:0]                 w2e_esto_vld,
  output logic [NUM_CH-1:0][DATA_W-1:0]     w2e_esto_data,
  output logic [NUM_CH-1:0]                 e2w_wsto_vld,
  output logic [NUM_CH-1:0][DATA_W-1:0]     e2w_wsto_data,
  output logic [NUM_CH-1:0]                 sr2sw_vld,
  output logic [NUM_CH-1:0][DATA_W-1:0]     sr2sw_data,
  input  logic [NUM_CH-1:0]                 cfg_tile_connected_prev,
  input  logic [NUM_CH-1:0]                 cfg_tile_connected_next,
  input  logic [NUM_CH-1:0]                 cfg_ch_en,
  input  logic [NUM_CH-1:0]                 cfg_parity_inv,
  input  logic                              cnt_clr,
  output logic [NUM_CH-1:0][CNT_W-1:0]      stat_pkt_cnt
);

  localparam int W = DATA_W + 1;

  logic tile_id_unused;
  assign tile_id_unused = ^glb_tile_id[TILE_SEL_ADDR_WIDTH-1:1];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic         even;
    logic         clr;
    logic [W-1:0] w_in, e_in, s_in;
    logic [W-1:0] w_p, e_p, s_d1;
    logic [W-1:0] w_turn, e_turn, w_turn_d1, e_turn_d1;
    logic [W-1:0] sr2sw_int, w2e_int, e2w_int;
    logic [CNT_W-1:0] cnt;

    assign even = ch_is_even(glb_tile_id[0], cfg_parity_inv[c]);
    assign clr  = ~cfg_ch_en[c];

    // Data is zeroed at entry so every stage holds data=0 whenever valid=0.
    assign w_in = w2e_wsti_vld[c] ? {1'b1, w2e_wsti_data[c]} : '0;
    assign e_in = e2w_esti_vld[c] ? {1'b1, e2w_esti_data[c]} : '0;
    assign s_in = sw2sr_vld[c]    ? {1'b1, sw2sr_data[c]}    : '0;

    glb_strm_pipe #(.DEPTH(PIPE_DEPTH), .WIDTH(W)) u_w_pipe (
      .clk(clk), .reset(reset), .clk_en(clk_en), .clr(clr), .d(w_in), .q(w_p));
    glb_strm_pipe #(.DEPTH(PIPE_DEPTH), .WIDTH(W)) u_e_pipe (
      .clk(clk), .reset(reset), .clk_en(clk_en), .clr(clr), .d(e_in), .q(e_p));
    glb_strm_pipe #(.DEPTH(1), .WIDTH(W)) u_s_pipe (
      .clk(clk), .reset(reset), .clk_en(clk_en), .clr(clr), .d(s_in), .q(s_d1));

    // Turnaround stages are what keep the unconnected-both-ends case loop free.
    glb_strm_pipe #(.DEPTH(1), .WIDTH(W)) u_wt_pipe (
      .clk(clk), .reset(reset), .clk_en(clk_en), .clr(clr), .d(w_turn), .q(w_turn_d1));
    glb_strm_pipe #(.DEPTH(1), .WIDTH(W)) u_et_pipe (
      .clk(clk), .reset(reset), .clk_en(clk_en), .clr(clr), .d(e_turn), .q(e_turn_d1));

    assign w_turn    = cfg_tile_connected_prev[c] ? w_p : e2w_int;
    assign e_turn    = cfg_tile_connected_next[c] ? e_p : w2e_int;
    assign sr2sw_int = even ? w_turn    : e_turn;
    assign w2e_int   = even ? s_d1      : w_turn_d1;
    assign e2w_int   = even ? e_turn_d1 : s_d1;

    assign {sr2sw_vld[c],    sr2sw_data[c]}    = cfg_ch_en[c] ? sr2sw_int : '0;
    assign {w2e_esto_vld[c], w2e_esto_data[c]} = cfg_ch_en[c] ? w2e_int   : '0;
    assign {e2w_wsto_vld[c], e2w_wsto_data[c]} = cfg_ch_en[c] ? e2w_int   : '0;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if (clk_en) begin
        if (cnt_clr) begin
          cnt <= '0;
        end else if (sr2sw_int[DATA_W] && cfg_ch_en[c] && (cnt != '1)) begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign stat_pkt_cnt[c] = cnt;
  end

endmodule
